fu_shift: RTL and testbench
===========================

# fu_shift

Pipelined, multi-mode shift functional unit for the out-of-order execution core: a parametrised successor to the single-mode arithmetic-right-shift unit. Accepts one tagged shift operation per cycle, performs SLL, SRL or SRA (optionally ROR) across a configurable number of pipeline stages, and holds each result until the broadcast queue takes it. Sits between the reservation-station dispatch (`ce`/`idle`) and the broadcast queue (`done`/`queued`). Supports a flush that kills every in-flight operation.

## Interface
- DATA_WIDTH, 32, operand/result width; power of two, ≥ 8.
- LATENCY, 2, capture-to-`done` latency in cycles; ≥ 1.
- TAG_WIDTH, 7, execution tag width.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  dispatch strobe; accepted only when `idle`=1.
- op  input  2  mode: 00 SLL, 01 SRL, 11 SRA, 10 ROR/SRL (see Configuration).
- executionTag_in  input  TAG_WIDTH  tag of dispatched op.
- data_0  input  DATA_WIDTH  shift amount; only low log2(DATA_WIDTH) bits used.
- data_1  input  DATA_WIDTH  value to shift.
- flush  input  1  kill all in-flight ops.
- queued  input  1  broadcast queue accepts the current result this cycle.
- idle  output  1  unit can accept `ce` this cycle.
- done  output  1  `result`/`executionTag_out` valid.
- result  output  DATA_WIDTH  shifted value.
- executionTag_out  output  TAG_WIDTH  tag of `result`.

## Operation
- Pipeline: stage 0 (input register) through stage LATENCY (output register); each stage holds valid, op, tag, partial data. `done` = stage LATENCY valid.
- Mux levels of the barrel shifter may be distributed across stages freely; only the result at stage LATENCY is specified.
- Shift amount sh = data_0[log2(DATA_WIDTH)-1:0]. SLL: data_1 << sh. SRL: logical right. SRA: sign-filled right (data_1 treated signed). sh = 0 returns data_1 unchanged.
- Advance: stage LATENCY holds while `done` & ~`queued`; stage k advances iff stage k+1 is empty or advancing. Bubbles collapse.
- `idle` = stage 0 empty or advancing. Must not depend combinationally on `ce`.
- `ce` while `idle`=0: ignored, no state change (illegal; bench asserts it never happens).
- `flush`: at the edge, clears every stage valid; `done` low next cycle. `ce` in the same cycle as `flush` is accepted and survives (flush kills only older ops). `queued` in the same cycle is still honoured by the queue; the unit drops the entry either way.
- `rst`: all valids 0, `done`=0, `result`=0, `executionTag_out`=0, `idle`=1 after the edge. Mid-operation reset discards everything; `rst` overrides `ce` and `flush`.
- Output fields are held stable while `done`=1 and not `queued`.

## Timing
- Op captured at edge E0 (`ce`=1, `idle`=1); `done`=1 after edge E0+LATENCY if not stalled.
- Throughput 1 op/cycle while `queued` is kept high with `done`.
- Maximum occupancy LATENCY+1 ops. On full stall, `idle`=0 until `queued`.
- `queued` with `done`: entry leaves at that edge; a following entry, if any, shows `done`=1 the next cycle, with no bubble.

## Configuration
- FU_SHIFT_ROTATE_EN defined: op=10 performs rotate right by sh (bits shifted out of LSB re-enter at MSB).
- Undefined: op=10 behaves exactly as SRL; no rotate logic synthesised.

## Test plan
- SRA, DATA_WIDTH=32, LATENCY=2: data_1=0x80000000, data_0=4, tag 0x15, `queued` tied 1 -> `done`=1 two cycles after capture, result 0xF8000000, tag 0x15.
- Amount masking: SLL data_1=0x00000001, data_0=33 -> 0x00000002. SRL data_1=0x80000000, data_0=31 -> 0x00000001.
- Back-to-back: 5 ops on consecutive cycles, `queued`=1 -> 5 consecutive `done` cycles, results and tags in order.
- Backpressure: `queued`=0 and 4 ops issued -> `idle` drops after 3 accepted; result/tag frozen; releasing `queued` drains in order, one per cycle.
- Flush: 2 ops in flight, `flush` together with new `ce` (tag 0x7F) -> only tag 0x7F ever reaches `done`. `rst` mid-flight -> `done`=0, `result`=0, `idle`=1 next cycle.
- op=10, data_1=0x00000001, data_0=1 -> 0x80000000 with FU_SHIFT_ROTATE_EN, 0x00000000 without.

Source files
------------

// File: rtl/fu_shift.sv
// fu_shift: pipelined SLL/SRL/SRA shift unit with valid/queued handshake.
// Define FU_SHIFT_ROTATE_EN to make op=10 a rotate right instead of SRL.
module fu_shift #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int TAG_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [1:0]            op,
  input  logic [TAG_WIDTH-1:0]  executionTag_in,
  input  logic [DATA_WIDTH-1:0] data_0,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic                  flush,
  input  logic                  queued,
  output logic                  idle,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  executionTag_out
);

  localparam int SW = $clog2(DATA_WIDTH);
  localparam int L  = LATENCY;

  // Stage 0 is the input register, stage L the output register.
  logic [L:0]            v_q;
  logic [1:0]            op_q  [L];
  logic [SW-1:0]         sh_q  [L];
  logic [TAG_WIDTH-1:0]  tag_q [L+1];
  logic [DATA_WIDTH-1:0] dat_q [L+1];
  logic [L:0]            free;

  // Upper shift-amount bits are ignored by definition.
  logic unused_hi;
  assign unused_hi = ^data_0[DATA_WIDTH-1:SW];

  function automatic logic [DATA_WIDTH-1:0] do_shift(
    input logic [1:0]            o,
    input logic [SW-1:0]         s,
    input logic [DATA_WIDTH-1:0] d
  );
    logic [DATA_WIDTH-1:0] r;
    logic [SW-1:0]         ns;
    ns = -s;
    r  = '0;
    case (o)
      2'b00: r = d << s;
      2'b11: r = $signed(d) >>> s;
`ifdef FU_SHIFT_ROTATE_EN
      2'b10: r = (d >> s) | (d << ns);
`endif
      default: r = d >> s;
    endcase
`ifndef FU_SHIFT_ROTATE_EN
    if (ns == '1) r = r;
`endif
    return r;
  endfunction

  // A stage is free when empty or when everything downstream moves.
  always_comb begin
    logic f;
    free = '0;
    f = ~v_q[L] | queued;
    free[L] = f;
    for (int k = L - 1; k >= 0; k--) begin
      f = ~v_q[k] | f;
      free[k] = f;
    end
  end

  // Pipeline advance, capture, flush and reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k <= L; k++) begin
        tag_q[k] <= '0;
        dat_q[k] <= '0;
      end
      for (int k = 0; k < L; k++) begin
        op_q[k] <= '0;
        sh_q[k] <= '0;
      end
    end else begin
      if (free[0]) begin
        v_q[0] <= ce;
        if (ce) begin
          op_q[0]  <= op;
          sh_q[0]  <= data_0[SW-1:0];
          tag_q[0] <= executionTag_in;
          dat_q[0] <= data_1;
        end
      end
      for (int k = 1; k < L; k++) begin
        if (free[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            op_q[k]  <= op_q[k-1];
            sh_q[k]  <= sh_q[k-1];
            tag_q[k] <= tag_q[k-1];
            dat_q[k] <= dat_q[k-1];
          end
        end
      end
      if (free[L]) begin
        v_q[L] <= v_q[L-1];
        if (v_q[L-1]) begin
          tag_q[L] <= tag_q[L-1];
          dat_q[L] <= do_shift(op_q[L-1], sh_q[L-1], dat_q[L-1]);
        end
      end
      if (flush) begin
        v_q <= {{L{1'b0}}, ce & free[0]};
      end
    end
  end

  assign idle             = free[0];
  assign done             = v_q[L];
  assign result           = dat_q[L];
  assign executionTag_out = tag_q[L];

endmodule

// File: tb/tb_fu_shift.sv
// tb_fu_shift: table vectors plus a scoreboard for fu_shift
// (DATA_WIDTH=32, LATENCY=2, TAG_WIDTH=7).
module tb_fu_shift;

  logic        clk = 1'b0;
  logic        rst, ce, flush, queued;
  logic [1:0]  op;
  logic [6:0]  tag_in, tag_o;
  logic [31:0] data_0, data_1, result, exp_in;
  logic        idle, done;

  int total = 0;
  int bad   = 0;
  logic [38:0] sbq[$];

`ifdef FU_SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  always #5 clk = ~clk;

  fu_shift #(.DATA_WIDTH(32), .LATENCY(2), .TAG_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .ce(ce), .op(op),
    .executionTag_in(tag_in), .data_0(data_0), .data_1(data_1),
    .flush(flush), .queued(queued), .idle(idle), .done(done),
    .result(result), .executionTag_out(tag_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [6:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] d);
    logic [31:0] r;
    int s;
    s = int'(a[4:0]);
    r = '0;
    for (int i = 0; i < 32; i++) begin
      case (o)
        2'b00: r[i] = (i >= s) ? d[i-s] : 1'b0;
        2'b11: r[i] = (i + s < 32) ? d[i+s] : d[31];
        2'b10: r[i] = ROT ? d[(i+s)%32]
                          : ((i + s < 32) ? d[i+s] : 1'b0);
        default: r[i] = (i + s < 32) ? d[i+s] : 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] d, input logic [6:0] t,
                       input logic [31:0] e);
    ce     = 1'b1;
    op     = o;
    data_0 = a;
    data_1 = d;
    tag_in = t;
    exp_in = e;
  endtask

  // Scoreboard: check head on done, pop on queued, push on accept.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (done) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got tag %0h want none", tag_o);
        end else begin
          chk("out_tag", 64'(tag_o), 64'(sbq[0][38:32]));
          chk("out_res", 64'(result), 64'(sbq[0][31:0]));
          if (queued) void'(sbq.pop_front());
        end
      end
      if (flush) sbq.delete();
      if (ce) begin
        if (!idle) begin
          total++;
          bad++;
          $display("FAIL ce_busy: got idle 0 want 1");
        end else begin
          sbq.push_back({tag_in, exp_in});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{2'b11, 32'd4,  32'h8000_0000, 7'h15, 32'hF800_0000};
    tbl[1]  = '{2'b00, 32'd33, 32'h0000_0001, 7'h01, 32'h0000_0002};
    tbl[2]  = '{2'b01, 32'd31, 32'h8000_0000, 7'h02, 32'h0000_0001};
    tbl[3]  = '{2'b00, 32'd0,  32'h1234_5678, 7'h03, 32'h1234_5678};
    tbl[4]  = '{2'b11, 32'd4,  32'h7FFF_FFF0, 7'h04, 32'h07FF_FFFF};
    tbl[5]  = '{2'b11, 32'd31, 32'h8000_0001, 7'h05, 32'hFFFF_FFFF};
    tbl[6]  = '{2'b00, 32'd31, 32'hFFFF_FFFF, 7'h06, 32'h8000_0000};
    tbl[7]  = '{2'b01, 32'd8,  32'hF0F0_F0F0, 7'h07, 32'h00F0_F0F0};
    tbl[8]  = '{2'b00, 32'd16, 32'h0000_ABCD, 7'h08, 32'hABCD_0000};
    tbl[9]  = '{2'b11, 32'd0,  32'hF000_0000, 7'h09, 32'hF000_0000};
    tbl[10] = '{2'b10, 32'd1,  32'h0000_0001, 7'h0A,
                ROT ? 32'h8000_0000 : 32'h0000_0000};
    tbl[11] = '{2'b10, 32'd8,  32'h0000_0100, 7'h0B, 32'h0000_0001};

    rst = 1'b1; ce = 1'b0; flush = 1'b0; queued = 1'b0;
    op = '0; data_0 = '0; data_1 = '0; tag_in = '0; exp_in = '0;
    tick();
    tick();
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    rst = 1'b0;

    // Latency of a single SRA op.
    queued = 1'b1;
    issue(tbl[0].op, tbl[0].d0, tbl[0].d1, tbl[0].tag, tbl[0].exp);
    tick();
    ce = 1'b0;
    chk("lat_e0", 64'(done), 64'd0);
    tick();
    chk("lat_e1", 64'(done), 64'd0);
    tick();
    chk("lat_e2", 64'(done), 64'd1);
    chk("lat_res", 64'(result), 64'hF800_0000);
    chk("lat_tag", 64'(tag_o), 64'h15);
    tick();
    chk("lat_gone", 64'(done), 64'd0);

    // Back-to-back table vectors at full throughput.
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].op, tbl[i].d0, tbl[i].d1, tbl[i].tag, tbl[i].exp);
      tick();
      if (i >= 2) chk("b2b_done", 64'(done), 64'd1);
    end
    ce = 1'b0;
    tick();
    chk("b2b_tail1", 64'(done), 64'd1);
    tick();
    chk("b2b_tail2", 64'(done), 64'd1);
    tick();
    chk("b2b_empty", 64'(done), 64'd0);

    // Backpressure: three fill the pipe, fourth waits for idle.
    queued = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(2'b00, 32'(i + 1), 32'h0000_0011, 7'(8'h21 + i),
            model(2'b00, 32'(i + 1), 32'h0000_0011));
      tick();
      chk("bp_idle", 64'(idle), (i == 2) ? 64'd0 : 64'd1);
    end
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_done", 64'(done), 64'd1);
      chk("bp_hold_tag", 64'(tag_o), 64'h21);
      chk("bp_hold_idle", 64'(idle), 64'd0);
    end
    queued = 1'b1;
    #1;
    chk("bp_release_idle", 64'(idle), 64'd1);
    issue(2'b01, 32'd4, 32'hABCD_0000, 7'h24,
          model(2'b01, 32'd4, 32'hABCD_0000));
    tick();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_drain", 64'(done), 64'd1);
      tick();
    end
    chk("bp_drained", 64'(done), 64'd0);

    // Flush with a same-cycle dispatch.
    queued = 1'b0;
    issue(2'b00, 32'd1, 32'h1, 7'h01, model(2'b00, 32'd1, 32'h1));
    tick();
    issue(2'b00, 32'd2, 32'h1, 7'h02, model(2'b00, 32'd2, 32'h1));
    tick();
    flush = 1'b1;
    issue(2'b11, 32'd8, 32'h8000_1234, 7'h7F,
          model(2'b11, 32'd8, 32'h8000_1234));
    tick();
    flush = 1'b0;
    ce = 1'b0;
    chk("fl_done0", 64'(done), 64'd0);
    tick();
    chk("fl_done1", 64'(done), 64'd0);
    tick();
    chk("fl_done2", 64'(done), 64'd1);
    chk("fl_tag", 64'(tag_o), 64'h7F);
    chk("fl_res", 64'(result), 64'hFF80_0012);
    queued = 1'b1;
    tick();
    chk("fl_gone", 64'(done), 64'd0);

    // Reset in the middle of a stalled pipe.
    queued = 1'b0;
    issue(2'b00, 32'd4, 32'h0000_00FF, 7'h33,
          model(2'b00, 32'd4, 32'h0000_00FF));
    tick();
    issue(2'b01, 32'd1, 32'h0000_00FF, 7'h34,
          model(2'b01, 32'd1, 32'h0000_00FF));
    tick();
    ce = 1'b0;
    tick();
    chk("mr_pre_done", 64'(done), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_result", 64'(result), 64'd0);
    chk("mr_tag", 64'(tag_o), 64'd0);
    chk("mr_idle", 64'(idle), 64'd1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 80; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rd;
      queued = ($urandom_range(0, 3) != 0);
      ce = 1'b0;
      #1;
      if (idle && $urandom_range(0, 3) != 0) begin
        ro = 2'($urandom_range(0, 3));
        ra = $urandom;
        rd = $urandom;
        issue(ro, ra, rd, 7'($urandom_range(0, 127)), model(ro, ra, rd));
      end
      tick();
    end
    ce = 1'b0;
    queued = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0 && !done) break;
      tick();
    end
    chk("drain_queue", 64'(sbq.size()), 64'd0);
    chk("drain_done", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
